// File: rtl/param_demux_router.sv
// Registered 1-to-N demultiplexer with a one-beat output slot per channel.
// Beats are routed to in_sel, broadcast to all channels, or dropped and counted.
module param_demux_router #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [CNT_W-1:0] DROP_MAX = '1;

    logic [N_CH-1:0]              valid_q, valid_d;
    logic [N_CH-1:0][DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]             drop_q, drop_d;
    logic [N_CH-1:0]              free, route_oh, load;
    logic [31:0]                  sel_ext;
    logic                         sel_ok;
    logic                         accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == DROP_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        sel_ext  = 32'(in_sel);
        sel_ok   = sel_ext < 32'(N_CH);
        // A slot being drained this cycle can take a new beat at the same edge.
        free     = ~valid_q | out_ready;
        route_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            route_oh[i] = sel_ok && (sel_ext == 32'(i));
        end

        if (rst) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = |(route_oh & free);
        end else begin
            in_ready = 1'b1;
        end

        accept  = in_valid & in_ready;
        load    = '0;
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < N_CH; i++) begin
            load[i]    = accept & (in_bcast | route_oh[i]);
            valid_d[i] = load[i] | (valid_q[i] & ~out_ready[i]);
            if (load[i]) begin
                data_d[i] = in_data;
            end
        end

        drop_d = (accept & ~in_bcast & ~sel_ok) ? sat_inc(drop_q) : drop_q;
    end

    // Output slot register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_param_demux_router.sv
// Table-driven bench for param_demux_router with a per-channel data scoreboard.
module tb_param_demux_router;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;

    param_demux_router #(.DATA_W(8), .N_CH(4), .SEL_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [2:0] sel;
        logic       bc;
        logic [7:0] dat;
        logic [3:0] ordy;
        logic       rdy;
        logic [3:0] ov;
        logic [7:0] drop;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb [4][$];
    vec_t       tbl [$];

    function automatic vec_t mk(input logic r, input logic iv, input logic [2:0] s,
                                input logic b, input logic [7:0] d, input logic [3:0] o,
                                input logic rdy, input logic [3:0] ov, input logic [7:0] dr);
        vec_t v;
        v.rst = r; v.iv = iv; v.sel = s; v.bc = b; v.dat = d;
        v.ordy = o; v.rdy = rdy; v.ov = ov; v.drop = dr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, check in_ready and held data, then check registered state after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        rst       = v.rst;
        in_valid  = v.iv;
        in_sel    = v.sel;
        in_bcast  = v.bc;
        in_data   = v.dat;
        out_ready = v.ordy;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
        for (int c = 0; c < 4; c++) begin
            if (out_valid[c] === 1'b1) begin
                if (sb[c].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s.ch%0d_unexpected: got valid data %0h, expected empty slot",
                             tag, c, out_data[c*8 +: 8]);
                end else begin
                    chk($sformatf("%s.ch%0d_data", tag, c), 32'(out_data[c*8 +: 8]), 32'(sb[c][0]));
                    if (out_ready[c]) void'(sb[c].pop_front());
                end
            end
        end
        if (v.rst) begin
            for (int c = 0; c < 4; c++) sb[c].delete();
        end else if (v.iv && v.rdy) begin
            for (int c = 0; c < 4; c++) begin
                if (v.bc || (v.sel == 3'(c))) sb[c].push_back(v.dat);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.ov));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(v.drop));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0;
        in_data = '0; out_ready = '0;

        // T1: reset held two cycles with traffic present
        run_vec(mk(1, 1, 3'd0, 0, 8'h11, 4'hF, 0, 4'h0, 8'd0), "t1a");
        run_vec(mk(1, 1, 3'd5, 1, 8'h22, 4'h0, 0, 4'h0, 8'd0), "t1b");
        chk("t1.out_data_zero", out_data, 32'h0);

        // T2: single routed beat
        tbl.push_back(mk(0, 1, 3'd2, 0, 8'hA5, 4'hF, 1, 4'b0100, 8'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'd0));
        // T3: ch1 stalled, ch3 flows, then back-to-back drain+load on ch1
        tbl.push_back(mk(0, 1, 3'd1, 0, 8'h11, 4'b1101, 1, 4'b0010, 8'd0));
        tbl.push_back(mk(0, 1, 3'd1, 0, 8'h22, 4'b1101, 0, 4'b0010, 8'd0));
        tbl.push_back(mk(0, 1, 3'd3, 0, 8'h33, 4'b1101, 1, 4'b1010, 8'd0));
        tbl.push_back(mk(0, 1, 3'd1, 0, 8'h22, 4'b1101, 0, 4'b0010, 8'd0));
        tbl.push_back(mk(0, 1, 3'd1, 0, 8'h22, 4'b1111, 1, 4'b0010, 8'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 8'h00, 4'b1111, 1, 4'b0000, 8'd0));
        // T4: broadcast waits for ch2 to drain, then lands on all channels together
        tbl.push_back(mk(0, 1, 3'd2, 0, 8'h44, 4'b1011, 1, 4'b0100, 8'd0));
        tbl.push_back(mk(0, 1, 3'd0, 1, 8'h3C, 4'b1011, 0, 4'b0100, 8'd0));
        tbl.push_back(mk(0, 1, 3'd0, 1, 8'h3C, 4'b1011, 0, 4'b0100, 8'd0));
        tbl.push_back(mk(0, 1, 3'd0, 1, 8'h3C, 4'b1111, 1, 4'b1111, 8'd0));
        tbl.push_back(mk(0, 0, 3'd0, 0, 8'h00, 4'b1111, 1, 4'b0000, 8'd0));
        // T5: invalid selects are consumed and counted; sel=4 is the first invalid index
        tbl.push_back(mk(0, 1, 3'd5, 0, 8'h55, 4'h0, 1, 4'h0, 8'd1));
        tbl.push_back(mk(0, 1, 3'd5, 0, 8'h56, 4'h0, 1, 4'h0, 8'd2));
        tbl.push_back(mk(0, 1, 3'd5, 0, 8'h57, 4'h0, 1, 4'h0, 8'd3));
        tbl.push_back(mk(0, 0, 3'd5, 0, 8'h00, 4'h0, 1, 4'h0, 8'd3));
        tbl.push_back(mk(0, 1, 3'd4, 0, 8'h58, 4'h0, 1, 4'h0, 8'd4));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Drop counter saturation
        for (int k = 0; k < 300; k++) begin
            int e;
            e = (5 + k > 255) ? 255 : 5 + k;
            run_vec(mk(0, 1, 3'd7, 0, 8'(k), 4'h0, 1, 4'h0, 8'(e)), "sat");
        end

        // T6: reset while ch0 and ch3 are full and stalled, then resend once
        run_vec(mk(0, 1, 3'd0, 0, 8'h60, 4'h0, 1, 4'b0001, 8'd255), "t6a");
        run_vec(mk(0, 1, 3'd3, 0, 8'h63, 4'h0, 1, 4'b1001, 8'd255), "t6b");
        run_vec(mk(1, 1, 3'd0, 0, 8'h77, 4'h0, 0, 4'b0000, 8'd0), "t6rst");
        chk("t6.out_data_zero", out_data, 32'h0);
        run_vec(mk(0, 1, 3'd0, 0, 8'h77, 4'hF, 1, 4'b0001, 8'd0), "t6c");
        run_vec(mk(0, 0, 3'd0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'd0), "t6d");
        run_vec(mk(0, 0, 3'd0, 0, 8'h00, 4'hF, 1, 4'b0000, 8'd0), "t6e");

        for (int c = 0; c < 4; c++) begin
            chk($sformatf("sb_left_ch%0d", c), 32'(sb[c].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
